// File: rtl/fpu_hazard_ctrl_if.sv
// Decode/writeback/issue-control signal bundle for the FPU issue controller.
// The pipeline side drives decode and writeback fields (master); the
// controller returns stall, issue and scoreboard status (slave).
interface fpu_hazard_ctrl_if #(
    parameter int ASIZE   = 5,
    parameter int NREGS   = 32,
    parameter int CWIDTH  = 4,
    parameter int SCWIDTH = 16
);
    logic               id_valid;
    logic [ASIZE-1:0]   id_rs_l;
    logic [ASIZE-1:0]   id_rs_r;
    logic [ASIZE-1:0]   id_rd;
    logic               id_uses_l;
    logic               id_uses_r;
    logic               id_writes;
    logic [CWIDTH-1:0]  id_mc_cycles;
    logic               wb_valid;
    logic [ASIZE-1:0]   wb_rd;
    logic               stall_if;
    logic               issue;
    logic               bubble_ex;
    logic               ex_busy;
    logic [NREGS-1:0]   pending;
    logic [SCWIDTH-1:0] stall_count;

    modport master (
        output id_valid, id_rs_l, id_rs_r, id_rd, id_uses_l, id_uses_r,
               id_writes, id_mc_cycles, wb_valid, wb_rd,
        input  stall_if, issue, bubble_ex, ex_busy, pending, stall_count
    );

    modport slave (
        input  id_valid, id_rs_l, id_rs_r, id_rd, id_uses_l, id_uses_r,
               id_writes, id_mc_cycles, wb_valid, wb_rd,
        output stall_if, issue, bubble_ex, ex_busy, pending, stall_count
    );
endinterface

// File: rtl/fpu_hazard_ctrl.sv
// Issue controller for the four-stage FPU pipeline. Tracks outstanding
// destination writes in a scoreboard, stalls decode on RAW/WAW hazards and
// while a multi-cycle op holds EXE, and injects bubbles into ID/EX.
// Hazards look only at the registered scoreboard, so a writeback frees its
// register for issue one cycle after the wb_valid cycle (no forwarding).
module fpu_hazard_ctrl #(
    parameter int ASIZE   = 5,
    parameter int NREGS   = 32,
    parameter int CWIDTH  = 4,
    parameter int SCWIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    fpu_hazard_ctrl_if.slave bus
);
    logic [NREGS-1:0]   pend_vec;
    logic [NREGS-1:0]   pend_next;
    logic [CWIDTH-1:0]  busy_cnt;
    logic [SCWIDTH-1:0] stall_cnt;
    logic               raw;
    logic               waw;
    logic               busy;
    logic               stall;
    logic               accept;

    // Hazard detection and issue decision, purely combinational.
    always_comb begin
        raw    = (bus.id_uses_l & pend_vec[bus.id_rs_l])
               | (bus.id_uses_r & pend_vec[bus.id_rs_r]);
        waw    = bus.id_writes & pend_vec[bus.id_rd];
        busy   = (busy_cnt != '0);
        stall  = bus.id_valid & (raw | waw | busy);
        accept = bus.id_valid & ~stall;
    end

    assign bus.stall_if    = stall;
    assign bus.issue       = accept;
    assign bus.bubble_ex   = ~accept;
    assign bus.ex_busy     = busy;
    assign bus.pending     = pend_vec;
    assign bus.stall_count = stall_cnt;

    // Scoreboard next value: writeback clears first, issue sets last so set wins.
    always_comb begin
        pend_next = pend_vec;
        if (bus.wb_valid) begin
            pend_next[bus.wb_rd] = 1'b0;
        end
        if (accept && bus.id_writes) begin
            pend_next[bus.id_rd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vec <= '0;
        end else begin
            pend_vec <= pend_next;
        end
    end

    // EXE occupancy down-counter; an N-cycle op blocks the next issue N-1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if (accept && (bus.id_mc_cycles >= CWIDTH'(2))) begin
            busy_cnt <= bus.id_mc_cycles - CWIDTH'(1);
        end else if (busy) begin
            busy_cnt <= busy_cnt - CWIDTH'(1);
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + SCWIDTH'(1);
        end
    end
endmodule

// File: tb/tb_fpu_hazard_ctrl.sv
// Self-checking bench for fpu_hazard_ctrl: a cycle-indexed behavioural model
// (register array, "EXE free at cycle" timestamp, saturating integer count)
// checked every negedge, plus directed scenarios with literal expectations.
module tb_fpu_hazard_ctrl;
    localparam int ASIZE   = 5;
    localparam int NREGS   = 32;
    localparam int CWIDTH  = 4;
    localparam int SCWIDTH = 8;
    localparam int SMAX    = (1 << SCWIDTH) - 1;

    logic clk;
    logic rst_n;
    bit   check_en;
    int   checks;
    int   errors;

    fpu_hazard_ctrl_if #(.ASIZE(ASIZE), .NREGS(NREGS), .CWIDTH(CWIDTH),
                         .SCWIDTH(SCWIDTH)) bus ();

    fpu_hazard_ctrl #(.ASIZE(ASIZE), .NREGS(NREGS), .CWIDTH(CWIDTH),
                      .SCWIDTH(SCWIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    bit      mpend [NREGS];
    longint  cyc;
    longint  free_at;
    int      mstall;

    function automatic bit m_busy();
        return cyc < free_at;
    endfunction

    function automatic bit m_stall();
        bit raw;
        bit waw;
        raw = (bus.id_uses_l && mpend[bus.id_rs_l]) || (bus.id_uses_r && mpend[bus.id_rs_r]);
        waw = bus.id_writes && mpend[bus.id_rd];
        return bus.id_valid && (raw || waw || m_busy());
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mpend[i] = 1'b0;
            cyc     = 0;
            free_at = 0;
            mstall  = 0;
        end else begin
            bit st;
            bit is;
            st = m_stall();
            is = bus.id_valid && !st;
            if (st && mstall < SMAX) mstall++;
            if (bus.wb_valid) mpend[bus.wb_rd] = 1'b0;
            if (is && bus.id_writes) mpend[bus.id_rd] = 1'b1;
            if (is && bus.id_mc_cycles >= 2) free_at = cyc + longint'(bus.id_mc_cycles);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            logic [NREGS-1:0] epend;
            bit st;
            for (int i = 0; i < NREGS; i++) epend[i] = mpend[i];
            st = m_stall();
            chk("stall_if", 64'(bus.stall_if), 64'(st));
            chk("issue", 64'(bus.issue), 64'(bus.id_valid && !st));
            chk("bubble_ex", 64'(bus.bubble_ex), 64'(!(bus.id_valid && !st)));
            chk("ex_busy", 64'(bus.ex_busy), 64'(m_busy()));
            chk("pending", 64'(bus.pending), 64'(epend));
            chk("stall_count", 64'(bus.stall_count), 64'(mstall));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int rl, input bit ul, input int rr, input bit ur,
                         input int rd, input bit wr, input int mc);
        bus.id_valid     = v;
        bus.id_rs_l      = ASIZE'(rl);
        bus.id_uses_l    = ul;
        bus.id_rs_r      = ASIZE'(rr);
        bus.id_uses_r    = ur;
        bus.id_rd        = ASIZE'(rd);
        bus.id_writes    = wr;
        bus.id_mc_cycles = CWIDTH'(mc);
    endtask

    task automatic wb(input bit v, input int rd);
        bus.wb_valid = v;
        bus.wb_rd    = ASIZE'(rd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pending", 64'(bus.pending), 64'h0);
        chk("rst_ex_busy", 64'(bus.ex_busy), 64'h0);
        chk("rst_stall_count", 64'(bus.stall_count), 64'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        check_en = 1'b0;
        rst_n    = 1'b0;
        idle();
        repeat (2) step();
        chk("reset_pending", 64'(bus.pending), 64'h0);
        chk("reset_stall_if", 64'(bus.stall_if), 64'h0);
        chk("reset_issue", 64'(bus.issue), 64'h0);
        chk("reset_bubble", 64'(bus.bubble_ex), 64'h1);
        chk("reset_ex_busy", 64'(bus.ex_busy), 64'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        check_en = 1'b1;

        // Async reset with writes outstanding and EXE busy
        for (int i = 4; i <= 7; i++) begin
            drive(1, 0, 0, 0, 0, i, 1, 0);
            step();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 4);
        step();
        idle();
        @(negedge clk);
        chk("pre_rst_pending", 64'(bus.pending), 64'h0000_00F0);
        chk("pre_rst_ex_busy", 64'(bus.ex_busy), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_pending", 64'(bus.pending), 64'h0);
        chk("async_rst_ex_busy", 64'(bus.ex_busy), 64'h0);
        chk("async_rst_stall_count", 64'(bus.stall_count), 64'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // RAW on r3, cleared by writeback
        drive(1, 0, 0, 0, 0, 3, 1, 0);
        step();
        drive(1, 3, 1, 0, 0, 10, 1, 0);
        @(negedge clk);
        chk("raw_stall", 64'(bus.stall_if), 64'h1);
        chk("raw_bubble", 64'(bus.bubble_ex), 64'h1);
        step();
        wb(1, 3);
        @(negedge clk);
        chk("raw_stall_wb_cycle", 64'(bus.stall_if), 64'h1);
        step();
        wb(0, 0);
        @(negedge clk);
        chk("raw_issue_after_wb", 64'(bus.issue), 64'h1);
        chk("raw_pending3", 64'(bus.pending[3]), 64'h0);
        chk("raw_stall_count", 64'(bus.stall_count), 64'h2);
        step();
        idle();

        // WAW on r7, writeback frees it, then another writer to r9 issues
        drive(1, 0, 0, 0, 0, 7, 1, 0);
        step();
        drive(1, 0, 0, 0, 0, 7, 1, 0);
        wb(1, 7);
        @(negedge clk);
        chk("waw_stall", 64'(bus.stall_if), 64'h1);
        step();
        wb(0, 0);
        drive(1, 0, 0, 0, 0, 9, 1, 0);
        @(negedge clk);
        chk("waw_pending7", 64'(bus.pending[7]), 64'h0);
        chk("waw_issue9", 64'(bus.issue), 64'h1);
        step();
        drive(1, 0, 0, 0, 0, 12, 1, 0);
        wb(1, 12);
        @(negedge clk);
        chk("waw_pending9", 64'(bus.pending[9]), 64'h1);
        step();
        idle();
        @(negedge clk);
        chk("set_wins_pending12", 64'(bus.pending[12]), 64'h1);

        // Multi-cycle occupancy
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 4);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("mc4_busy", 64'(bus.ex_busy), 64'h1);
            chk("mc4_stall", 64'(bus.stall_if), 64'h1);
            step();
        end
        @(negedge clk);
        chk("mc4_follower_issue", 64'(bus.issue), 64'h1);
        chk("mc4_busy_done", 64'(bus.ex_busy), 64'h0);
        step();
        for (int m = 0; m <= 1; m++) begin
            drive(1, 0, 0, 0, 0, 0, 0, m);
            step();
            drive(1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk("mc_short_follower", 64'(bus.issue), 64'h1);
            chk("mc_short_busy", 64'(bus.ex_busy), 64'h0);
            step();
        end
        idle();

        // Unused source fields must not create hazards
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        step();
        drive(1, 5, 0, 5, 0, 6, 1, 0);
        @(negedge clk);
        chk("unused_src_issue", 64'(bus.issue), 64'h1);
        step();
        idle();

        // Randomized traffic on a small register window to provoke hazards
        repeat (3000) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 2) != 0,
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 1));
            wb($urandom_range(0, 1) != 0, $urandom_range(0, 7));
            step();
        end
        idle();

        // Stall counter saturation
        do_reset();
        drive(1, 0, 0, 0, 0, 20, 1, 0);
        step();
        drive(1, 20, 1, 0, 0, 21, 0, 0);
        repeat ((1 << SCWIDTH) + 5) step();
        @(negedge clk);
        chk("sat_stall_count", 64'(bus.stall_count), 64'(SMAX));
        chk("sat_stall_if", 64'(bus.stall_if), 64'h1);
        step();
        wb(1, 20);
        step();
        wb(0, 0);
        @(negedge clk);
        chk("sat_release_issue", 64'(bus.issue), 64'h1);
        chk("sat_hold", 64'(bus.stall_count), 64'(SMAX));
        step();
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
